// File: rtl/blur_stream_ctrl_pkg.sv
// Shared types and default geometry for the blur stream sequencer.
// Frame sizes, beat-counter width and the frame FSM encoding.
package blur_pkg;

  localparam int DW    = 8;
  localparam int IN_W  = 258;
  localparam int IN_H  = 258;
  localparam int OUT_W = 256;
  localparam int OUT_H = 256;

  localparam int IN_PIX  = IN_W * IN_H;
  localparam int OUT_PIX = OUT_W * OUT_H;

  function automatic int cnt_w(int a, int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

  localparam int CW = cnt_w(IN_PIX, OUT_PIX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/blur_stream_ctrl_if.sv
// Valid/ready/last stream bundle used on all four sides
// of the blur sequencer.
interface blur_stream_if #(
  parameter int DW = 8
);
  logic [DW-1:0] data;
  logic          valid;
  logic          ready;
  logic          last;

  modport master (
    output data,
    output valid,
    output last,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    input  last,
    output ready
  );
endinterface

// File: rtl/blur_stream_ctrl_gate.sv
// One gated stream: passes LIMIT beats while busy, counts them,
// regenerates last and flags a disagreeing upstream last.
module blur_beat_gate #(
  parameter int LIMIT = 16,
  parameter int CW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          busy,
  input  logic          clr,
  blur_stream_if.slave  up,
  blur_stream_if.master dn,
  output logic          fin,
  output logic          full,
  output logic          err
);

  localparam logic [CW-1:0] LIM  = CW'(LIMIT);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt;
  logic          open;
  logic          fire;

  assign open     = busy && (cnt < LIM);
  assign dn.data  = up.data;
  assign dn.valid = up.valid & open;
  assign up.ready = dn.ready & open;
  assign dn.last  = open && (cnt == LAST);
  assign fire     = up.valid & up.ready;
  assign fin      = fire & dn.last;
  assign full     = (cnt == LIM);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      err <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      err <= 1'b0;
    end else if (fire) begin
      cnt <= cnt + CW'(1);
      if (up.last != dn.last) err <= 1'b1;
    end
  end

endmodule

// File: rtl/blur_stream_ctrl.sv
// Frame sequencer between pixel source/sink and the blur accelerator.
// Optional busy-cycle counter: define BLUR_STREAM_CTRL_PERF_EN.
module blur_stream_ctrl #(
  parameter int DW    = blur_pkg::DW,
  parameter int IN_W  = blur_pkg::IN_W,
  parameter int IN_H  = blur_pkg::IN_H,
  parameter int OUT_W = blur_pkg::OUT_W,
  parameter int OUT_H = blur_pkg::OUT_H
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err_in_last,
  output logic          err_out_last,
  output logic [15:0]   frames,
  output logic [31:0]   perf_cycles,
  blur_stream_if.slave  s,
  blur_stream_if.master a,
  blur_stream_if.slave  r,
  blur_stream_if.master m
);
  import blur_pkg::*;

  localparam int NIN  = IN_W * IN_H;
  localparam int NOUT = OUT_W * OUT_H;
  localparam int NCW  = cnt_w(NIN, NOUT);

  state_t state, state_nx;
  logic   clr;
  logic   in_fin, in_full;
  logic   out_fin, out_full;

  blur_beat_gate #(.LIMIT(NIN), .CW(NCW)) u_in (
    .clk   (clk),
    .reset (reset),
    .busy  (busy),
    .clr   (clr),
    .up    (s),
    .dn    (a),
    .fin   (in_fin),
    .full  (in_full),
    .err   (err_in_last)
  );

  blur_beat_gate #(.LIMIT(NOUT), .CW(NCW)) u_out (
    .clk   (clk),
    .reset (reset),
    .busy  (busy),
    .clr   (clr),
    .up    (r),
    .dn    (m),
    .fin   (out_fin),
    .full  (out_full),
    .err   (err_out_last)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Early-finished output is tolerated: completion then hinges on input.
  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
          clr      = 1'b1;
        end
      end
      RUN: begin
        if (in_fin)
          state_nx = (out_fin || out_full) ? DONE : DRAIN;
      end
      DRAIN: begin
        if (out_fin || (out_full && in_full))
          state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset)     frames <= '0;
    else if (done) frames <= frames + 16'd1;
  end

`ifdef BLUR_STREAM_CTRL_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (reset)
      perf_q <= '0;
    else if (clr)
      perf_q <= '0;
    else if (busy && (perf_q != 32'hFFFF_FFFF))
      perf_q <= perf_q + 32'd1;
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_blur_stream_ctrl.sv
// Self-checking bench for blur_stream_ctrl on a 4x4 -> 2x2 frame,
// a frame-level model checked every cycle plus literal expectations.
module tb_blur_stream_ctrl;

  localparam int IN_PIX  = 16;
  localparam int OUT_PIX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy, done, err_in_last, err_out_last;
  logic [15:0] frames;
  logic [31:0] perf_cycles;

  blur_stream_if #(.DW(8)) s_if ();
  blur_stream_if #(.DW(8)) a_if ();
  blur_stream_if #(.DW(8)) r_if ();
  blur_stream_if #(.DW(8)) m_if ();

  blur_stream_ctrl #(
    .DW(8), .IN_W(4), .IN_H(4), .OUT_W(2), .OUT_H(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .err_in_last  (err_in_last),
    .err_out_last (err_out_last),
    .frames       (frames),
    .perf_cycles  (perf_cycles),
    .s            (s_if),
    .a            (a_if),
    .r            (r_if),
    .m            (m_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a frame is active until both beat quotas are met.
  bit          md_active, md_fin, md_err_in, md_err_out;
  int          md_in, md_out;
  logic [15:0] md_frames;
  logic [31:0] md_perf;

  always @(posedge clk) begin
    bit in_open, out_open, in_fire, out_fire;
    in_open  = md_active && md_in < IN_PIX;
    out_open = md_active && md_out < OUT_PIX;
    in_fire  = s_if.valid && a_if.ready && in_open;
    out_fire = r_if.valid && m_if.ready && out_open;
    if (reset) begin
      md_active = 0; md_fin = 0; md_in = 0; md_out = 0;
      md_frames = 0; md_err_in = 0; md_err_out = 0; md_perf = 0;
    end else if (md_fin) begin
      md_fin = 0;
      md_frames = md_frames + 16'd1;
    end else if (!md_active) begin
      if (start) begin
        md_active = 1; md_in = 0; md_out = 0;
        md_err_in = 0; md_err_out = 0; md_perf = 0;
      end
    end else begin
      if (md_perf != 32'hFFFF_FFFF) md_perf = md_perf + 1;
      if (in_fire) begin
        if (s_if.last != (md_in == IN_PIX - 1)) md_err_in = 1;
        md_in++;
      end
      if (out_fire) begin
        if (r_if.last != (md_out == OUT_PIX - 1)) md_err_out = 1;
        md_out++;
      end
      if (md_in == IN_PIX && md_out == OUT_PIX) begin
        md_active = 0;
        md_fin = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit in_open, out_open;
      in_open  = md_active && md_in < IN_PIX;
      out_open = md_active && md_out < OUT_PIX;
      chk("busy", busy, md_active);
      chk("done", done, md_fin);
      chk("err_in", err_in_last, md_err_in);
      chk("err_out", err_out_last, md_err_out);
      chk("frames", frames, md_frames);
`ifdef BLUR_STREAM_CTRL_PERF_EN
      chk("perf", perf_cycles, md_perf);
`else
      chk("perf", perf_cycles, 0);
`endif
      chk("s_ready", s_if.ready, a_if.ready && in_open);
      chk("a_valid", a_if.valid, s_if.valid && in_open);
      chk("a_last", a_if.last, in_open && md_in == IN_PIX - 1);
      chk("a_data", a_if.data, s_if.data);
      chk("r_ready", r_if.ready, m_if.ready && out_open);
      chk("m_valid", m_if.valid, r_if.valid && out_open);
      chk("m_last", m_if.last, out_open && md_out == OUT_PIX - 1);
      chk("m_data", m_if.data, r_if.data);
    end
  end

  int n_src, n_res, s_last_at, r_last_at;
  bit stall;
  int src_i, res_i, a_last_at, m_last_at, done_cnt;

  task automatic step();
    s_if.valid = (src_i < n_src) && (!stall || $urandom_range(1, 0) == 1);
    s_if.data  = 8'(src_i * 3 + 1);
    s_if.last  = s_if.valid && (src_i + 1 == s_last_at);
    a_if.ready = !stall || $urandom_range(1, 0) == 1;
    r_if.valid = (res_i < n_res) && (!stall || $urandom_range(1, 0) == 1);
    r_if.data  = 8'(res_i * 5 + 2);
    r_if.last  = r_if.valid && (res_i + 1 == r_last_at);
    m_if.ready = !stall || $urandom_range(1, 0) == 1;
    @(negedge clk);
    if (s_if.valid && s_if.ready) begin
      if (a_if.last) a_last_at = src_i + 1;
      src_i++;
    end
    if (r_if.valid && r_if.ready) begin
      if (m_if.last) m_last_at = res_i + 1;
      res_i++;
    end
    if (done) done_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(int ns, int nr, int sl, int rl, bit st, int mid);
    n_src = ns; n_res = nr; s_last_at = sl; r_last_at = rl; stall = st;
    src_i = 0; res_i = 0; a_last_at = 0; m_last_at = 0; done_cnt = 0;
    start = 1;
    step();
    for (int c = 0; c < 600 && done_cnt == 0; c++) begin
      start = (c == mid);
      step();
    end
    start = 0;
    step();
    step();
    chk("done_once", done_cnt, 1);
  endtask

  initial begin
    reset = 1; start = 0;
    n_src = 0; n_res = 0; s_last_at = 0; r_last_at = 0; stall = 0;
    src_i = 0; res_i = 0; a_last_at = 0; m_last_at = 0; done_cnt = 0;
    s_if.valid = 0; s_if.data = 0; s_if.last = 0;
    a_if.ready = 0;
    r_if.valid = 0; r_if.data = 0; r_if.last = 0;
    m_if.ready = 0;
    @(posedge clk);
    #1;
    chk_en = 1;
    step();
    reset = 0;
    step();
    chk("rst_busy", busy, 0);
    chk("rst_frames", frames, 0);

    // Abort a frame stuck in DRAIN (inputs done, outputs short).
    n_src = 16; n_res = 2; s_last_at = 16; r_last_at = 4; stall = 0;
    start = 1;
    step();
    start = 0;
    for (int c = 0; c < 20; c++) step();
    chk("drain_busy", busy, 1);
    chk("drain_in_cnt", src_i, 16);
    n_src = 0; n_res = 0;
    reset = 1;
    step();
    reset = 0;
    chk("abort_busy", busy, 0);
    chk("abort_s_ready", s_if.ready, 0);
    chk("abort_r_ready", r_if.ready, 0);
    chk("abort_frames", frames, 0);
    step();

    run_frame(16, 4, 16, 4, 0, -1);
    chk("f1_a_last_beat", a_last_at, 16);
    chk("f1_m_last_beat", m_last_at, 4);
    chk("f1_frames", frames, 1);
    chk("f1_err_in", err_in_last, 0);
    chk("f1_err_out", err_out_last, 0);
`ifdef BLUR_STREAM_CTRL_PERF_EN
    chk("f1_perf", perf_cycles, 16);
`else
    chk("f1_perf", perf_cycles, 0);
`endif

    run_frame(17, 4, 16, 4, 0, -1);
    chk("f2_in_beats", src_i, 16);
    chk("f2_frames", frames, 2);

    run_frame(16, 4, 16, 4, 1, 3);
    chk("f3_in_beats", src_i, 16);
    chk("f3_out_beats", res_i, 4);
    chk("f3_m_last_beat", m_last_at, 4);
    chk("f3_frames", frames, 3);

    run_frame(16, 4, 10, 4, 0, -1);
    chk("f4_err_in", err_in_last, 1);
    chk("f4_a_last_beat", a_last_at, 16);
    chk("f4_err_out", err_out_last, 0);

    run_frame(16, 4, 16, 4, 0, -1);
    chk("f5_err_in_clr", err_in_last, 0);
    chk("f5_frames", frames, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/blur_stream_ctrl.md
Name: blur_stream_ctrl

Overview:
Frame-level sequencer between the pixel stream source/sink and the blur accelerator's AXI-style valid/ready/last ports.
- Opens the input gate for exactly IN_W*IN_H pixels per start and the output gate for exactly OUT_W*OUT_H results.
- Regenerates `last` on both sides and flags misaligned `last` from source or accelerator.
- Reports busy/done per frame.
- Synthesizable; replaces ad-hoc bench sequencing of start/stop.

Parameters:
- DW, 8, pixel data width.
- IN_W, 258, input frame width in pixels.
- IN_H, 258, input frame height in pixels.
- OUT_W, 256, output frame width.
- OUT_H, 256, output frame height.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a frame.
- busy  out  1  high in RUN/DRAIN.
- done  out  1  one-cycle pulse at frame completion.
- err_in_last  out  1  sticky: s_last disagreed with expected input position.
- err_out_last  out  1  sticky: r_last disagreed with expected output position.
- frames  out  16  completed-frame count, wraps.
- perf_cycles  out  32  busy-cycle count (optional feature).
- s_data  in  DW; s_valid  in  1; s_ready  out  1; s_last  in  1: source stream.
- a_data  out  DW; a_valid  out  1; a_ready  in  1; a_last  out  1: to accelerator.
- r_data  in  DW; r_valid  in  1; r_ready  out  1; r_last  in  1: from accelerator.
- m_data  out  DW; m_valid  out  1; m_ready  in  1; m_last  out  1: to sink.

Behaviour:
- Reset: state IDLE; counters 0; busy, done, err_*, s_ready, a_valid, a_last, r_ready, m_valid, m_last all 0; frames 0; perf_cycles 0.
- Pass-through is combinational (zero latency):
  - a_data = s_data; m_data = r_data.
  - in_open = busy && in_cnt < IN_W*IN_H; out_open = busy && out_cnt < OUT_W*OUT_H.
  - a_valid = s_valid & in_open; s_ready = a_ready & in_open.
  - m_valid = r_valid & out_open; r_ready = m_ready & out_open.
- a_last = in_open && in_cnt == IN_W*IN_H-1; m_last = out_open && out_cnt == OUT_W*OUT_H-1. Incoming s_last/r_last never forwarded.
- in_cnt increments on s_valid&s_ready; out_cnt increments on r_valid&r_ready.
- Counter width: $clog2(max(IN_W*IN_H, OUT_W*OUT_H)+1).
- Last checks: on an accepted input beat, s_last != a_last sets err_in_last. Same for r_last vs m_last into err_out_last. Both errors clear on a start accepted in IDLE.
- FSM:
  - IDLE: start -> RUN. Clear counters and errors.
  - RUN: final input beat accepted -> DRAIN. If the final output beat is accepted in the same cycle -> DONE.
  - DRAIN: input gate closed; final output beat accepted -> DONE.
  - DONE: one cycle; done=1, frames+1, busy=0 -> IDLE.
- start outside IDLE is ignored; no queuing.
- Outputs complete before input completes (illegal for blur, tolerated): out gate closes, FSM waits in RUN for the remaining input.
- Reset mid-frame: immediate return to IDLE, gates closed next cycle. Downstream is not flushed.
- busy = state in {RUN, DRAIN}. done is a registered decode of the DONE state.

Optional Feature:
- Macro: BLUR_STREAM_CTRL_PERF_EN.
- Defined: perf_cycles clears on accepted start and increments every cycle busy=1, saturating at 2^32-1. Holds its value after done.
- Undefined: no counter logic; perf_cycles tied to 0.

Decomposition:
- Shared package blur_pkg:
  - Parameters DW, IN_W, IN_H, OUT_W, OUT_H, and derived IN_PIX / OUT_PIX.
  - Counter-width localparam.
  - FSM state enum {IDLE, RUN, DRAIN, DONE}.
- One natural sub-module: blur_beat_gate. Instantiated twice (input side, output side); holds the valid/ready gating, beat counter, last generation and last-mismatch check for one stream. Parameter: beat limit.

Test Plan:
- IN_W=IN_H=4, OUT_W=OUT_H=2. Start, source sends 16 beats with s_last on beat 16, accelerator returns 4 with r_last on beat 4, all ready -> a_last on beat 16, m_last on beat 4, done pulse once, frames=1, no errors.
- Same config, source presents a 17th beat -> s_ready=0 after beat 16, 17th beat never accepted, in_cnt stays 16.
- Random 1/2-probability stalls on s_valid (1-32 cycles) and m_ready -> exact beat counts, data order preserved, done after the 4th accepted output.
- s_last asserted on beat 10 -> err_in_last=1 from beat 10, a_last still only on beat 16. Next start clears err_in_last.
- start pulsed during RUN -> ignored, frames increments once. Reset asserted in DRAIN -> busy=0, s_ready=r_ready=0 next cycle, frames unchanged.
- With BLUR_STREAM_CTRL_PERF_EN, zero-stall 4x4 frame -> perf_cycles equals the number of busy cycles (16 with always-ready and simultaneous output). Without the macro, perf_cycles=0 throughout.
